// File: rtl/stage_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer_pkg
// Description : Shared stage codes and widths for the multi-cycle stage
//               sequencer and its datapath neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_sequencer_pkg;

   localparam int WORD_SIZE = 16;
   localparam int STAGE_W   = 3;

   // Codes 5 and 6 are deliberately unassigned; the FSM recovers them to IF.
   typedef enum logic [STAGE_W-1:0] {
      STAGE_IF   = 3'd0,
      STAGE_ID   = 3'd1,
      STAGE_EX   = 3'd2,
      STAGE_MEM  = 3'd3,
      STAGE_WB   = 3'd4,
      STAGE_HALT = 3'd7
   } stage_e;

endpackage
`default_nettype wire

// File: rtl/stage_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : stage_tick_gen
// Description : Advance-tick source: auto prescaler or synchronised step
//               button with rising-edge detect. STAGE_SEQ_DEBOUNCE_EN adds a
//               debounce filter in front of the edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_tick_gen #(
   parameter int AUTO_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic is_auto,
   input  logic next_stage,
   output logic tick
);

   localparam int c_presc_w = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(AUTO_DIV - 1);

   if (AUTO_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("stage_tick_gen: AUTO_DIV and DEBOUNCE_CYCLES must be >= 1");
   end

   logic [c_presc_w-1:0] r_presc;
   logic                 r_auto_q;
   logic                 r_auto_vld;
   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_level_q;
   logic                 w_level;
   logic                 w_mode_chg;
   logic                 w_presc_hit;

   // The first cycle after reset only samples is_auto so it is not seen as a change.
   assign w_mode_chg  = r_auto_vld & (is_auto ^ r_auto_q);
   assign w_presc_hit = (r_presc == c_presc_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc    <= '0;
         r_auto_q   <= 1'b0;
         r_auto_vld <= 1'b0;
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_level_q  <= 1'b0;
      end else begin
         r_auto_vld <= 1'b1;
         r_auto_q   <= is_auto;
         r_sync1    <= next_stage;
         r_sync2    <= r_sync1;
         r_level_q  <= w_level;
         if (w_mode_chg || !is_auto) begin
            r_presc <= '0;
         end else if (w_presc_hit) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + c_presc_w'(1);
         end
      end
   end

`ifdef STAGE_SEQ_DEBOUNCE_EN
   localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_db_w-1:0] c_db_max = c_db_w'(DEBOUNCE_CYCLES - 1);

   logic [c_db_w-1:0] r_db_cnt;
   logic              r_db_level;

   // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_db_cnt   <= '0;
         r_db_level <= 1'b0;
      end else if (r_sync2 == r_db_level) begin
         r_db_cnt   <= '0;
      end else if (r_db_cnt == c_db_max) begin
         r_db_cnt   <= '0;
         r_db_level <= r_sync2;
      end else begin
         r_db_cnt   <= r_db_cnt + c_db_w'(1);
      end
   end

   assign w_level = r_db_level;
`else
   assign w_level = r_sync2;
`endif

   always_comb begin
      tick = 1'b0;
      if (!w_mode_chg) begin
         if (is_auto) begin
            tick = w_presc_hit;
         end else begin
            tick = w_level & ~r_level_q;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer
// Description : Multi-cycle CPU stage controller IF->ID->EX->(MEM)->(WB)->IF
//               with datapath write strobes and a retired-instruction count.
//               Optional build macro: STAGE_SEQ_DEBOUNCE_EN (step debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int AUTO_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               is_auto,
   input  logic               next_stage,
   input  logic               need_mem,
   input  logic               need_wb,
   input  logic               is_halt,
   input  logic               mem_ready,
   output logic [STAGE_W-1:0] stage,
   output logic               ir_we,
   output logic               pc_we,
   output logic               reg_we,
   output logic               mem_en,
   output logic [CNT_W-1:0]   instr_count
);

   logic             w_tick;
   stage_e           r_stage;
   stage_e           w_next;
   logic             w_ir_we;
   logic             w_reg_we;
   logic             w_retire;
   logic [CNT_W-1:0] r_count;

   stage_tick_gen #(
      .AUTO_DIV        (AUTO_DIV),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_tick_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .is_auto    (is_auto),
      .next_stage (next_stage),
      .tick       (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= STAGE_IF;
      end else begin
         r_stage <= w_next;
      end
   end

   always_comb begin
      w_next   = r_stage;
      w_ir_we  = 1'b0;
      w_reg_we = 1'b0;
      w_retire = 1'b0;
      case (r_stage)
         STAGE_IF: begin
            if (w_tick) begin
               w_next  = STAGE_ID;
               w_ir_we = 1'b1;
            end
         end
         STAGE_ID: begin
            if (w_tick) begin
               w_next = is_halt ? STAGE_HALT : STAGE_EX;
            end
         end
         STAGE_EX: begin
            if (w_tick) begin
               if (need_mem) begin
                  w_next = STAGE_MEM;
               end else if (need_wb) begin
                  w_next = STAGE_WB;
               end else begin
                  w_next   = STAGE_IF;
                  w_retire = 1'b1;
               end
            end
         end
         // A tick while memory is busy is dropped, not queued.
         STAGE_MEM: begin
            if (w_tick && mem_ready) begin
               if (need_wb) begin
                  w_next = STAGE_WB;
               end else begin
                  w_next   = STAGE_IF;
                  w_retire = 1'b1;
               end
            end
         end
         STAGE_WB: begin
            if (w_tick) begin
               w_next   = STAGE_IF;
               w_reg_we = 1'b1;
               w_retire = 1'b1;
            end
         end
         STAGE_HALT: begin
            w_next = STAGE_HALT;
         end
         default: begin
            w_next = STAGE_IF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_retire) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign stage       = r_stage;
   assign ir_we       = w_ir_we;
   assign pc_we       = w_retire;
   assign reg_we      = w_reg_we;
   assign mem_en      = (r_stage == STAGE_MEM);
   assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_sequencer
// Description : Scoreboard bench for stage_sequencer (AUTO_DIV=4 main
//               instance, AUTO_DIV=1 / 8-bit counter instance for wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, rst_nw;
   logic       is_auto, next_stage, need_mem, need_wb, is_halt, mem_ready;
   logic [2:0] stage;
   logic       ir_we, pc_we, reg_we, mem_en;
   logic [15:0] instr_count;
   logic [2:0] w_stage;
   logic       w_ir, w_pc, w_reg, w_mem;
   logic [7:0] w_cnt;

   always #5 clk = ~clk;

   stage_sequencer #(.AUTO_DIV(4), .DEBOUNCE_CYCLES(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .is_auto(is_auto), .next_stage(next_stage),
      .need_mem(need_mem), .need_wb(need_wb), .is_halt(is_halt),
      .mem_ready(mem_ready), .stage(stage), .ir_we(ir_we), .pc_we(pc_we),
      .reg_we(reg_we), .mem_en(mem_en), .instr_count(instr_count)
   );

   // Free-running NOP stream, one tick per cycle, for the counter wrap.
   stage_sequencer #(.AUTO_DIV(1), .DEBOUNCE_CYCLES(16), .CNT_W(8)) dut_w (
      .clk(clk), .rst_n(rst_nw), .is_auto(1'b1), .next_stage(1'b0),
      .need_mem(1'b0), .need_wb(1'b0), .is_halt(1'b0),
      .mem_ready(1'b0), .stage(w_stage), .ir_we(w_ir), .pc_we(w_pc),
      .reg_we(w_reg), .mem_en(w_mem), .instr_count(w_cnt)
   );

   typedef struct {
      int stg;
      bit ir;
      bit pc;
      bit rg;
      int dwell;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc = 0, last_chg = 0;
   int   n_ir = 0, n_pc = 0, n_reg = 0;
   logic p_ir = 1'b0, p_pc = 1'b0, p_reg = 1'b0;
   logic [2:0] p_stage = 3'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void push(int s, bit ir, bit pc, bit rg, int dw);
      exp_t e;
      e.stg = s; e.ir = ir; e.pc = pc; e.rg = rg; e.dwell = dw;
      sb.push_back(e);
   endfunction

   // Each stage change pops one expected entry; strobes are those seen in the tick cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      cyc++;
      if (!rst_n) begin
         p_stage  = stage;
         last_chg = cyc;
         p_ir = 1'b0; p_pc = 1'b0; p_reg = 1'b0;
      end else begin
         n_ir  += int'(ir_we);
         n_pc  += int'(pc_we);
         n_reg += int'(reg_we);
         if (stage !== p_stage) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_step", 32'(stage), 32'(p_stage));
            end else begin
               e = sb.pop_front();
               chk("sb_stage", 32'(stage), e.stg);
               chk("sb_ir_we", 32'(p_ir), 32'(e.ir));
               chk("sb_pc_we", 32'(p_pc), 32'(e.pc));
               chk("sb_reg_we", 32'(p_reg), 32'(e.rg));
               if (e.dwell != 0) chk("sb_dwell", cyc - last_chg, e.dwell);
            end
            last_chg = cyc;
            p_stage  = stage;
         end
         p_ir = ir_we; p_pc = pc_we; p_reg = reg_we;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_sb(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         cycles(1);
         n++;
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   task automatic press(input int hi, input int lo);
      next_stage = 1'b1;
      cycles(hi);
      next_stage = 1'b0;
      cycles(lo);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int saved;
      int n;
      rst_n = 1'b0; rst_nw = 1'b0;
      is_auto = 1'b1; next_stage = 1'b0;
      need_mem = 1'b0; need_wb = 1'b1; is_halt = 1'b0; mem_ready = 1'b0;
      cycles(3);
      chk("rst_stage", 32'(stage), 0);
      chk("rst_ir_we", 32'(ir_we), 0);
      chk("rst_pc_we", 32'(pc_we), 0);
      chk("rst_reg_we", 32'(reg_we), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_count", 32'(instr_count), 0);

      // ALU instruction in auto mode
      push(1, 1, 0, 0, 0); push(2, 0, 0, 0, 4); push(4, 0, 0, 0, 4); push(0, 0, 1, 1, 4);
      rst_n = 1'b1;
      wait_sb(40);
      is_auto = 1'b0;
      chk("alu_count", 32'(instr_count), 1);
      chk("alu_n_reg", n_reg, 1);

      // Load with memory stall
      need_mem = 1'b1; need_wb = 1'b1; mem_ready = 1'b0;
      push(1, 1, 0, 0, 0); push(2, 0, 0, 0, 4); push(3, 0, 0, 0, 4);
      is_auto = 1'b1;
      wait_sb(60);
      cycles(13);
      chk("stall_stage", 32'(stage), 3);
      chk("stall_mem_en", 32'(mem_en), 1);
      chk("stall_n_pc", n_pc, 1);
      mem_ready = 1'b1;
      push(4, 0, 0, 0, 0); push(0, 0, 1, 1, 4);
      wait_sb(20);
      is_auto = 1'b0; mem_ready = 1'b0;
      chk("load_count", 32'(instr_count), 2);
      chk("load_mem_en_off", 32'(mem_en), 0);
      chk("load_n_reg", n_reg, 2);

      // Manual NOP: one step per press
      need_mem = 1'b0; need_wb = 1'b0;
      push(1, 1, 0, 0, 0); press(20, 20);
      push(2, 0, 0, 0, 0); press(20, 20);
      push(0, 0, 1, 0, 0); press(20, 20);
      wait_sb(10);
      chk("manual_count", 32'(instr_count), 3);
      push(1, 1, 0, 0, 0); press(100, 20);
      wait_sb(5);
      chk("hold_single_step", 32'(stage), 1);
      chk("hold_n_ir", n_ir, 4);
      push(2, 0, 0, 0, 0); press(20, 20);

      // HALT is sticky
      push(0, 0, 1, 0, 0); press(20, 20);
      push(1, 1, 0, 0, 0); press(20, 20);
      is_halt = 1'b1;
      push(7, 0, 0, 0, 0); press(20, 20);
      wait_sb(5);
      chk("halt_stage", 32'(stage), 7);
      chk("halt_count", 32'(instr_count), 4);
      saved = n_ir + n_pc + n_reg;
      repeat (10) press(20, 20);
      is_auto = 1'b1;
      cycles(40);
      chk("halt_sticky", 32'(stage), 7);
      chk("halt_no_strobes", n_ir + n_pc + n_reg, saved);
      rst_n = 1'b0;
      #1;
      chk("halt_rst_stage", 32'(stage), 0);
      chk("halt_rst_count", 32'(instr_count), 0);
      is_auto = 1'b0; is_halt = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(2);

      // Short glitch, then a clean pulse
`ifdef STAGE_SEQ_DEBOUNCE_EN
      press(5, 30);
      chk("glitch_ignored", 32'(stage), 0);
      push(1, 1, 0, 0, 0); press(20, 30);
      wait_sb(5);
      push(2, 0, 0, 0, 0); press(20, 30);
      wait_sb(5);
`else
      push(1, 1, 0, 0, 0); press(5, 30);
      wait_sb(5);
      push(2, 0, 0, 0, 0); press(20, 30);
      wait_sb(5);
`endif
      chk("pre_rst_ex", 32'(stage), 2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ex", 32'(stage), 0);
      chk("async_rst_ir_we", 32'(ir_we), 0);
      cycles(2);
      rst_n = 1'b1;

      // Counter wrap on the 8-bit instance
      rst_nw = 1'b1;
      n = 0;
      while (w_cnt !== 8'hFF && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_pre", 32'(w_cnt), 32'hFF);
      n = 0;
      while (w_pc !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_pc_we", 32'(w_pc), 1);
      chk("wrap_stage_ex", 32'(w_stage), 2);
      @(negedge clk);
      chk("wrap_zero", 32'(w_cnt), 0);
      chk("wrap_stage_if", 32'(w_stage), 0);

      cycles(2);
      chk("sb_final_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
